mips_pipe_skid: RTL

Parametrised pipeline stage register for the Sample MIPS pipeline, the successor to the fixed EX/MEM latch. It carries an opaque payload of PAYLOAD_W bits between two stages using a valid/ready handshake, with a two-entry skid buffer so that the upstream ready is fully registered. It supports synchronous flush with bubble insertion. An optional performance-counter feature reports stall and bubble cycles. One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/mips_pipe_pkg.sv | 28 ++
 rtl/mips_sat_counter.sv | 20 ++
 rtl/mips_pipe_skid.sv | 112 +++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the Sample MIPS pipeline stage registers:
// EX/MEM payload layout and the skid-buffer occupancy states.
package mips_pipe_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 3;

    typedef struct packed {
        logic [DATA_W-1:0]    alu_result;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rdst;
        logic                 regw;
        logic                 memr;
        logic                 memw;
    } ex_mem_t;

    localparam int EX_MEM_W = DATA_W + 3 * REG_IDX_W + CTRL_W;

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter used for the stage performance counters.
module mips_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_pipe_skid.sv
// Valid/ready pipeline stage register with a two-entry skid buffer and flush.
// Define MIPS_PIPE_PERF_EN to build the stall/bubble performance counters.
module mips_pipe_skid
    import mips_pipe_pkg::*;
#(
    parameter int PAYLOAD_W = EX_MEM_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    skid_state_t          r_state, w_state_nxt;
    logic [PAYLOAD_W-1:0] r_m_data, r_s_data;
    logic [PAYLOAD_W-1:0] w_m_data_nxt, w_s_data_nxt;
    logic                 w_in_fire, w_out_fire;

    // Handshake outputs are pure decodes of the state register.
    assign in_ready   = (r_state != ST_FULL);
    assign out_valid  = (r_state != ST_EMPTY);
    assign out_data   = r_m_data;
    assign occupancy  = 2'(r_state);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_m_data_nxt = r_m_data;
        w_s_data_nxt = r_s_data;
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_m_data_nxt = '0;
            w_s_data_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt  = ST_ONE;
                        w_m_data_nxt = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_m_data_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt  = ST_FULL;
                        w_s_data_nxt = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt  = ST_EMPTY;
                        w_m_data_nxt = '0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt  = ST_ONE;
                        w_m_data_nxt = r_s_data;
                        w_s_data_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt  = ST_EMPTY;
                    w_m_data_nxt = '0;
                    w_s_data_nxt = '0;
                end
            endcase
        end
    end

    // NOTE: data registers are reset and zeroed on emptying so idle slots read as bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_EMPTY;
            r_m_data <= '0;
            r_s_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_m_data <= w_m_data_nxt;
            r_s_data <= w_s_data_nxt;
        end
    end

`ifdef MIPS_PIPE_PERF_EN
    mips_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    mips_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
